if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction buffer between the fetch stage and decode.
- Captures each fetched word together with its PC and the fetch-stage branch-prediction bit (IF_take).
- Holds up to DEPTH entries in FIFO order and presents the oldest entry to ID.
- Absorbs load-use stalls and drops all entries on a misprediction flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_INST, 32'h00000013, instruction word driven to ID when no valid entry (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- inst_mem_read_data  input  32  instruction word for inst_mem_read_addr, same cycle.
- inst_mem_read_addr  input  32  PC of the word being fetched.
- IF_take  input  1  fetch-stage prediction bit for this word.
- fetch_valid  input  1  word/PC/take presented this cycle is a real fetch.
- fetch_ready  output  1  queue can accept a word this cycle; IF holds its PC when low.
- EX_MEM_flush  input  1  misprediction; discard everything.
- EX_MEM_stall  input  1  load-use stall; ID must not consume.
- IF_ID_inst  output  32  head instruction (NOP_INST when IF_ID_valid=0).
- IF_ID_pc  output  32  head PC (0 when invalid).
- IF_ID_take  output  1  head prediction bit (0 when invalid).
- IF_ID_valid  output  1  head entry valid.
- IF_ID_count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH x {inst[31:0], pc[31:0], take}. Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- Reset (reset=0, async): pointers=0, count=0, IF_ID_valid=0, IF_ID_inst=NOP_INST, IF_ID_pc=0, IF_ID_take=0, fetch_ready=1. Reset mid-operation discards all entries immediately. Entry contents are not cleared.
- fetch_ready = (count != DEPTH). Purely from registered count; no combinational path from EX_MEM_stall or EX_MEM_flush.
- Enqueue when fetch_valid && fetch_ready && !EX_MEM_flush: write at wr_ptr, wr_ptr+1.
- Dequeue when IF_ID_valid && !EX_MEM_stall && !EX_MEM_flush: rd_ptr+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Full: enqueue refused even if a dequeue happens the same cycle. The fetch stage re-presents the word next cycle.
- Empty (feature off): an enqueued word is visible on IF_ID_* the next cycle. Enqueue-to-head latency is 1 cycle.
- IF_ID_* are driven from the entry at rd_ptr when count>0, otherwise the invalid defaults.
- EX_MEM_flush has highest priority after reset:
  - count=0 and pointers=0 next cycle.
  - Same-cycle fetch dropped; same-cycle dequeue suppressed.
  - IF_ID_valid=0 the cycle after the flush.
- EX_MEM_stall and EX_MEM_flush both high: flush wins.
- EX_MEM_stall does not block enqueue; the queue keeps filling until full.
- Stall held for many cycles: head entry and outputs stable; count saturates at DEPTH.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined: when count==0 and fetch_valid && !EX_MEM_flush, the incoming word/PC/take drive IF_ID_* combinationally with IF_ID_valid=1 (0-cycle latency).
  - If !EX_MEM_stall, the word is consumed directly and not written; count stays 0.
  - If EX_MEM_stall, it is written normally and appears as head next cycle.
- Undefined: no bypass; behaviour exactly as in Behaviour.

Test Plan:
- Reset low mid-stream with count=3 -> immediately IF_ID_valid=0, IF_ID_inst=32'h00000013, IF_ID_count=0, fetch_ready=1.
- Feature off; enqueue PC 0x00, 0x04, 0x08 on consecutive cycles with stall=0 -> IF_ID_pc shows 0x00, 0x04, 0x08 one cycle after each; count stays 1.
- EX_MEM_stall=1 for 6 cycles while fetch_valid=1 (DEPTH=4) -> count reaches 4, fetch_ready=0 from cycle 5, head PC unchanged. Release stall -> 4 entries drain in order, fetch_ready=1 after the first dequeue.
- Count=3 with IF_take=1 on the head, assert EX_MEM_flush with fetch_valid=1 and stall=1 -> next cycle count=0, IF_ID_valid=0. Next fetch PC 0x40 becomes head with IF_ID_take matching its input.
- Full queue, fetch_valid=1 and a dequeue in the same cycle -> incoming word not stored, count=3. Word accepted the following cycle, order preserved.
- IF_ID_QUEUE_BYPASS_EN defined, empty queue, fetch PC 0x10 with stall=0 -> IF_ID_valid=1 and IF_ID_pc=0x10 in the same cycle, count remains 0.

Source files
------------

// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue_if
//  Description : Fetch-side and decode-side signal bundle for if_id_queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_id_queue_if #(
   parameter int DEPTH = 4
);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]        inst_mem_read_data;
   logic [31:0]        inst_mem_read_addr;
   logic               IF_take;
   logic               fetch_valid;
   logic               fetch_ready;
   logic               EX_MEM_flush;
   logic               EX_MEM_stall;
   logic [31:0]        IF_ID_inst;
   logic [31:0]        IF_ID_pc;
   logic               IF_ID_take;
   logic               IF_ID_valid;
   logic [c_CNT_W-1:0] IF_ID_count;

   // Pipeline side: drives fetch words and hazard controls, observes the head.
   modport master (
      output inst_mem_read_data, inst_mem_read_addr, IF_take, fetch_valid,
             EX_MEM_flush, EX_MEM_stall,
      input  fetch_ready, IF_ID_inst, IF_ID_pc, IF_ID_take, IF_ID_valid,
             IF_ID_count
   );

   // Queue side.
   modport slave (
      input  inst_mem_read_data, inst_mem_read_addr, IF_take, fetch_valid,
             EX_MEM_flush, EX_MEM_stall,
      output fetch_ready, IF_ID_inst, IF_ID_pc, IF_ID_take, IF_ID_valid,
             IF_ID_count
   );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : IF/ID instruction FIFO with stall absorption and flush.
//                Optional 0-cycle empty bypass under IF_ID_QUEUE_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  wire logic     clk,
   input  wire logic     reset,
   if_id_queue_if.slave  ifq
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

   logic [31:0]         r_inst [DEPTH];
   logic [31:0]         r_pc   [DEPTH];
   logic                r_take [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_full;
   logic                w_empty;
   logic                w_bypass;
   logic                w_enq;
   logic                w_deq;

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);

`ifdef IF_ID_QUEUE_BYPASS_EN
   assign w_bypass = w_empty && ifq.fetch_valid && !ifq.EX_MEM_flush;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed word that ID consumes directly never enters storage.
   assign w_enq = ifq.fetch_valid && !w_full && !ifq.EX_MEM_flush
                  && !(w_bypass && !ifq.EX_MEM_stall);
   assign w_deq = !w_empty && !ifq.EX_MEM_stall && !ifq.EX_MEM_flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (ifq.EX_MEM_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         unique case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is never reset; validity is tracked only by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_inst[r_wr_ptr] <= ifq.inst_mem_read_data;
         r_pc[r_wr_ptr]   <= ifq.inst_mem_read_addr;
         r_take[r_wr_ptr] <= ifq.IF_take;
      end
   end

   always_comb begin
      ifq.IF_ID_inst  = NOP_INST;
      ifq.IF_ID_pc    = 32'h0;
      ifq.IF_ID_take  = 1'b0;
      ifq.IF_ID_valid = 1'b0;
      if (!w_empty) begin
         ifq.IF_ID_inst  = r_inst[r_rd_ptr];
         ifq.IF_ID_pc    = r_pc[r_rd_ptr];
         ifq.IF_ID_take  = r_take[r_rd_ptr];
         ifq.IF_ID_valid = 1'b1;
      end else if (w_bypass) begin
         ifq.IF_ID_inst  = ifq.inst_mem_read_data;
         ifq.IF_ID_pc    = ifq.inst_mem_read_addr;
         ifq.IF_ID_take  = ifq.IF_take;
         ifq.IF_ID_valid = 1'b1;
      end
   end

   assign ifq.fetch_ready = !w_full;
   assign ifq.IF_ID_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_queue
//  Description : Randomized scoreboard bench for if_id_queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_queue;

   localparam int          c_DEPTH = 4;
   localparam logic [31:0] c_NOP   = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        take;
   } ent_t;

   logic clk;
   logic reset;

   if_id_queue_if #(.DEPTH(c_DEPTH)) bus ();

   if_id_queue #(.DEPTH(c_DEPTH), .NOP_INST(c_NOP)) dut (
      .clk   (clk),
      .reset (reset),
      .ifq   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_pass  = 0;
   int   n_total = 0;
   bit   mon_en  = 1'b0;

   ent_t exp_q[$];
   bit   pend_push  = 1'b0;
   bit   pend_flush = 1'b0;
   ent_t pend_e;

   logic [31:0] fpc;
   logic [31:0] finst;
   logic        ftake;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor: compares the presented head and pops on consumption.
   always @(negedge clk) begin
      bit   ev;
      ent_t e;
      if (mon_en) begin
         ev = (exp_q.size() > 0);
         e  = ev ? exp_q[0] : '{pc: 32'h0, inst: c_NOP, take: 1'b0};
`ifdef IF_ID_QUEUE_BYPASS_EN
         if (!ev && bus.fetch_valid && !bus.EX_MEM_flush) begin
            ev = 1'b1;
            e  = '{pc: bus.inst_mem_read_addr, inst: bus.inst_mem_read_data,
                   take: bus.IF_take};
         end
`endif
         chk("count", 32'(bus.IF_ID_count), 32'(exp_q.size()));
         chk("fetch_ready", 32'(bus.fetch_ready), 32'(exp_q.size() < c_DEPTH));
         chk("valid", 32'(bus.IF_ID_valid), 32'(ev));
         chk("head_pc", bus.IF_ID_pc, e.pc);
         chk("head_inst", bus.IF_ID_inst, e.inst);
         chk("head_take", 32'(bus.IF_ID_take), 32'(e.take));
         if (exp_q.size() > 0 && !bus.EX_MEM_stall && !bus.EX_MEM_flush)
            void'(exp_q.pop_front());
      end
   end

   task automatic commit();
      if (pend_flush) exp_q.delete();
      else if (pend_push) exp_q.push_back(pend_e);
      pend_push  = 1'b0;
      pend_flush = 1'b0;
   endtask

   // One cycle of stimulus; 'took' reports whether the fetch stage may advance.
   task automatic drive(input bit fv, input logic [31:0] pc, input logic [31:0] inst,
                        input bit tk, input bit st, input bit fl, output bit took);
      @(posedge clk);
      #1;
      commit();
      bus.fetch_valid        = fv;
      bus.inst_mem_read_addr = pc;
      bus.inst_mem_read_data = inst;
      bus.IF_take            = tk;
      bus.EX_MEM_stall       = st;
      bus.EX_MEM_flush       = fl;
      took       = fv && !fl && (exp_q.size() < c_DEPTH);
      pend_flush = fl;
      pend_e     = '{pc: pc, inst: inst, take: tk};
      pend_push  = took;
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (exp_q.size() == 0 && !st) pend_push = 1'b0;
`endif
   endtask

   task automatic fetch_cycle(input bit fv, input bit st, input bit fl);
      bit took;
      drive(fv, fpc, finst, ftake, st, fl, took);
      if (fl) begin
         fpc   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         finst = $urandom();
         ftake = 1'($urandom_range(0, 1));
      end else if (took) begin
         fpc   = fpc + 32'd4;
         finst = $urandom();
         ftake = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      bit dummy;
      reset = 1'b0;
      bus.fetch_valid        = 1'b0;
      bus.inst_mem_read_addr = 32'h0;
      bus.inst_mem_read_data = 32'h0;
      bus.IF_take            = 1'b0;
      bus.EX_MEM_stall       = 1'b0;
      bus.EX_MEM_flush       = 1'b0;
      fpc   = 32'h0;
      finst = $urandom();
      ftake = 1'b0;

      #2;
      chk("rst_valid", 32'(bus.IF_ID_valid), 32'h0);
      chk("rst_inst", bus.IF_ID_inst, c_NOP);
      chk("rst_pc", bus.IF_ID_pc, 32'h0);
      chk("rst_take", 32'(bus.IF_ID_take), 32'h0);
      chk("rst_count", 32'(bus.IF_ID_count), 32'h0);
      chk("rst_ready", 32'(bus.fetch_ready), 32'h1);
      @(posedge clk);
      #3;
      reset  = 1'b1;
      mon_en = 1'b1;

      // Back-to-back fetches with no stall: PC 0x00, 0x04, 0x08.
      repeat (3) fetch_cycle(1'b1, 1'b0, 1'b0);
      repeat (2) fetch_cycle(1'b0, 1'b0, 1'b0);

      // Long stall fills the queue, then drains in order.
      repeat (6) fetch_cycle(1'b1, 1'b1, 1'b0);
      repeat (5) fetch_cycle(1'b0, 1'b0, 1'b0);

      // Three entries with a predicted-taken head, then flush with fetch and stall.
      ftake = 1'b1;
      repeat (3) fetch_cycle(1'b1, 1'b1, 1'b0);
      drive(1'b1, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, dummy);
      drive(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b1, 1'b1, 1'b0, dummy);
      repeat (2) fetch_cycle(1'b0, 1'b0, 1'b0);

      // Full queue: dequeue and fetch in the same cycle, fetch re-presented.
      fpc = 32'h0000_0100;
      repeat (4) fetch_cycle(1'b1, 1'b1, 1'b0);
      repeat (2) fetch_cycle(1'b1, 1'b0, 1'b0);
      repeat (5) fetch_cycle(1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of traffic with three entries held.
      repeat (3) fetch_cycle(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      commit();
      chk("pre_reset_count", 32'(bus.IF_ID_count), 32'd3);
      mon_en = 1'b0;
      bus.fetch_valid  = 1'b0;
      bus.EX_MEM_stall = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.IF_ID_valid), 32'h0);
      chk("mid_rst_inst", bus.IF_ID_inst, c_NOP);
      chk("mid_rst_count", 32'(bus.IF_ID_count), 32'h0);
      chk("mid_rst_ready", 32'(bus.fetch_ready), 32'h1);
      exp_q.delete();
      pend_push  = 1'b0;
      pend_flush = 1'b0;
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;

      // Randomized traffic with bursts of long stalls.
      for (int i = 0; i < 3000; i++) begin
         bit st;
         if ((i / 50) % 4 == 3) st = ($urandom_range(0, 9) < 8);
         else                   st = ($urandom_range(0, 9) < 3);
         fetch_cycle($urandom_range(0, 9) < 7, st, $urandom_range(0, 24) == 0);
      end
      repeat (DEPTH_DRAIN()) fetch_cycle(1'b0, 1'b0, 1'b0);

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   function automatic int DEPTH_DRAIN();
      return c_DEPTH + 2;
   endfunction

endmodule
`default_nettype wire
